// File: rtl/dac_feedback_pi.sv
// dac_feedback_pi: PI loop filter turning signed phase-error samples into the
// offset-binary feedback word for the DAC output register stage.
// One update per accepted sample, five-state pipeline FSM, clamped integrator,
// saturated and held output.
// Optional feature: define SLEW_LIMIT_EN to limit the per-update output step to
// SLEW_MAX codes.
module dac_feedback_pi #(
  parameter int unsigned    DW       = 16,
  parameter int unsigned    SHIFT    = 12,
  parameter int unsigned    IW       = 40,
  parameter logic [DW-1:0]  OUT_INIT = 16'h8000,
  parameter int unsigned    SLEW_MAX = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic signed [15:0]   kp,
  input  logic signed [15:0]   ki,
  input  logic signed [DW-1:0] err_in,
  input  logic                 err_valid,
  output logic                 err_ready,
  output logic [DW-1:0]        feedback_data,
  output logic                 fb_valid,
  output logic                 sat_flag
);

  // Product width (16-bit gain x DW-bit error) and widened adder width.
  localparam int unsigned PW = 16 + DW;
  localparam int unsigned AW = IW + 1;

  // Integrator limit is the largest positive output scaled by the gain fraction.
  localparam logic signed [AW-1:0] IntegMax =
      AW'(((64'sd1 <<< (DW - 1)) - 64'sd1) <<< SHIFT);
  localparam logic signed [AW-1:0] IntegMin = -IntegMax;
  localparam logic signed [AW-1:0] OutMax   = AW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] OutMin   = -OutMax - AW'(1);
  localparam logic signed [DW-1:0] UMax     = {1'b0, {(DW - 1){1'b1}}};
  localparam logic signed [DW-1:0] UMin     = {1'b1, {(DW - 1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StMul, StAcc, StSum, StOut} state_e;

  state_e state_q, state_d;

  logic signed [DW-1:0] err_q, err_d;
  logic signed [15:0]   kp_q, kp_d;
  logic signed [15:0]   ki_q, ki_d;
  logic signed [PW-1:0] p_q, p_d;
  logic signed [PW-1:0] ii_q, ii_d;
  logic signed [IW-1:0] integ_q, integ_d;
  logic signed [DW-1:0] u_q, u_d;
  logic                 u_sat_q, u_sat_d;
  logic [DW-1:0]        fb_data_q, fb_data_d;
  logic                 fb_valid_q, fb_valid_d;
  logic                 sat_q, sat_d;

  logic                 accept;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] pi_sum;
  logic signed [AW-1:0] pi_shift;
  logic [DW-1:0]        target;

`ifdef SLEW_LIMIT_EN
  localparam logic signed [DW+1:0] SlewLim  = (DW + 2)'(SLEW_MAX);
  localparam logic [DW-1:0]        SlewStep = DW'(SLEW_MAX);
  logic signed [DW+1:0] slew_diff;
`else
  logic unused_slew;
  assign unused_slew = ^SLEW_MAX;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed walk through the pipeline, enable low aborts.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (accept) state_d = StMul;
        StMul:   state_d = StAcc;
        StAcc:   state_d = StSum;
        StSum:   state_d = StOut;
        StOut:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: ready only in idle; acceptance needs the loop enabled.
  always_comb begin
    err_ready = (state_q == StIdle);
    accept    = err_ready & err_valid & enable;
  end

  // Datapath arithmetic shared by the ACC and SUM stages.
  always_comb begin
    acc_sum  = $signed({{(AW - IW){integ_q[IW-1]}}, integ_q})
             + $signed({{(AW - PW){ii_q[PW-1]}}, ii_q});
    pi_sum   = $signed({{(AW - PW){p_q[PW-1]}}, p_q})
             + $signed({{(AW - IW){integ_q[IW-1]}}, integ_q});
    pi_shift = pi_sum >>> SHIFT;
    // Two's complement to offset binary is a flip of the sign bit.
    target   = {~u_q[DW-1], u_q[DW-2:0]};
  end

  // Datapath next-state: one pipeline step per FSM state.
  always_comb begin
    err_d      = err_q;
    kp_d       = kp_q;
    ki_d       = ki_q;
    p_d        = p_q;
    ii_d       = ii_q;
    integ_d    = integ_q;
    u_d        = u_q;
    u_sat_d    = u_sat_q;
    fb_data_d  = fb_data_q;
    sat_d      = sat_q;
    fb_valid_d = 1'b0;
`ifdef SLEW_LIMIT_EN
    slew_diff  = $signed({2'b00, target}) - $signed({2'b00, fb_data_q});
`endif
    if (!enable) begin
      integ_d   = '0;
      fb_data_d = OUT_INIT;
      sat_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            err_d = err_in;
            kp_d  = kp;
            ki_d  = ki;
          end
        end
        StMul: begin
          p_d  = $signed({{DW{kp_q[15]}}, kp_q}) * $signed({{16{err_q[DW-1]}}, err_q});
          ii_d = $signed({{DW{ki_q[15]}}, ki_q}) * $signed({{16{err_q[DW-1]}}, err_q});
        end
        StAcc: begin
          if (acc_sum > IntegMax) begin
            integ_d = IntegMax[IW-1:0];
          end else if (acc_sum < IntegMin) begin
            integ_d = IntegMin[IW-1:0];
          end else begin
            integ_d = acc_sum[IW-1:0];
          end
        end
        StSum: begin
          if (pi_shift > OutMax) begin
            u_d     = UMax;
            u_sat_d = 1'b1;
          end else if (pi_shift < OutMin) begin
            u_d     = UMin;
            u_sat_d = 1'b1;
          end else begin
            u_d     = pi_shift[DW-1:0];
            u_sat_d = 1'b0;
          end
        end
        StOut: begin
          fb_valid_d = 1'b1;
`ifdef SLEW_LIMIT_EN
          if (slew_diff > SlewLim) begin
            fb_data_d = fb_data_q + SlewStep;
            sat_d     = 1'b1;
          end else if (slew_diff < -SlewLim) begin
            fb_data_d = fb_data_q - SlewStep;
            sat_d     = 1'b1;
          end else begin
            fb_data_d = target;
            sat_d     = u_sat_q;
          end
`else
          fb_data_d = target;
          sat_d     = u_sat_q;
`endif
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= '0;
      kp_q       <= '0;
      ki_q       <= '0;
      p_q        <= '0;
      ii_q       <= '0;
      integ_q    <= '0;
      u_q        <= '0;
      u_sat_q    <= 1'b0;
      fb_data_q  <= OUT_INIT;
      fb_valid_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      err_q      <= err_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      p_q        <= p_d;
      ii_q       <= ii_d;
      integ_q    <= integ_d;
      u_q        <= u_d;
      u_sat_q    <= u_sat_d;
      fb_data_q  <= fb_data_d;
      fb_valid_q <= fb_valid_d;
      sat_q      <= sat_d;
    end
  end

  assign feedback_data = fb_data_q;
  assign fb_valid      = fb_valid_q;
  assign sat_flag      = sat_q;

endmodule

// File: tb/tb_dac_feedback_pi.sv
// Directed self-checking bench for dac_feedback_pi (default parameters).
module tb_dac_feedback_pi;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic signed [15:0] kp;
  logic signed [15:0] ki;
  logic signed [15:0] err_in;
  logic               err_valid;
  logic               err_ready;
  logic [15:0]        feedback_data;
  logic               fb_valid;
  logic               sat_flag;

  int n_vec = 0;
  int n_err = 0;

  dac_feedback_pi dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .kp            (kp),
    .ki            (ki),
    .err_in        (err_in),
    .err_valid     (err_valid),
    .err_ready     (err_ready),
    .feedback_data (feedback_data),
    .fb_valid      (fb_valid),
    .sat_flag      (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse enable low for one edge to clear the loop state.
  task automatic clear_loop();
    enable = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  // Drive one sample through the handshake and collect what the DUT produced.
  task automatic run_sample(input logic signed [15:0] e, input logic signed [15:0] k_p,
                            input logic signed [15:0] k_i, output logic [15:0] data,
                            output logic sat, output int lat, output logic busy_rdy,
                            output logic rdy_at_out, output logic pulse_after);
    int w;
    w = 0;
    while (!err_ready && w < 10) begin
      tick();
      w++;
    end
    err_in    = e;
    kp        = k_p;
    ki        = k_i;
    err_valid = 1'b1;
    tick();
    err_valid = 1'b0;
    // Scramble inputs after capture; they must not affect this sample.
    err_in    = 16'($urandom);
    kp        = 16'($urandom);
    ki        = 16'($urandom);
    busy_rdy  = err_ready;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!fb_valid && lat < 12);
    data       = feedback_data;
    sat        = sat_flag;
    rdy_at_out = err_ready;
    tick();
    pulse_after = fb_valid;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    kp        = '0;
    ki        = '0;
    err_in    = '0;
    err_valid = 1'b0;
    #12;
    n_vec++;
    if (feedback_data !== 16'h8000) begin
      n_err++; $display("FAIL reset_data got %h want 8000", feedback_data);
    end
    n_vec++;
    if (fb_valid !== 1'b0 || sat_flag !== 1'b0 || err_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_flags got v=%b s=%b r=%b want v=0 s=0 r=1",
               fb_valid, sat_flag, err_ready);
    end
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_proportional();
    logic [15:0] d; logic s, br, ro, pa; int lat;
    clear_loop();
    run_sample(16'sd100, 16'sh1000, 16'sh0000, d, s, lat, br, ro, pa);
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL p_latency got %0d want 4", lat); end
    n_vec++;
    if (d !== 16'h8064) begin n_err++; $display("FAIL p_data got %h want 8064", d); end
    n_vec++;
    if (s !== 1'b0) begin n_err++; $display("FAIL p_sat got %b want 0", s); end
    n_vec++;
    if (br !== 1'b0) begin n_err++; $display("FAIL p_busy_ready got %b want 0", br); end
    n_vec++;
    if (ro !== 1'b1) begin n_err++; $display("FAIL p_ready_back got %b want 1", ro); end
    n_vec++;
    if (pa !== 1'b0) begin n_err++; $display("FAIL p_pulse_len got %b want 0", pa); end
    n_vec++;
    if (feedback_data !== 16'h8064) begin
      n_err++; $display("FAIL p_hold got %h want 8064", feedback_data);
    end
  endtask

  task automatic test_out_clamp();
    logic [15:0] d; logic s, br, ro, pa; int lat;
    clear_loop();
    run_sample(16'sh7FFF, 16'sh7FFF, 16'sh0000, d, s, lat, br, ro, pa);
    n_vec++;
    if (d !== 16'hFFFF || s !== 1'b1) begin
      n_err++; $display("FAIL clamp_pos got %h/%b want ffff/1", d, s);
    end
    run_sample(16'sh8000, 16'sh7FFF, 16'sh0000, d, s, lat, br, ro, pa);
    n_vec++;
    if (d !== 16'h0000 || s !== 1'b1) begin
      n_err++; $display("FAIL clamp_neg got %h/%b want 0000/1", d, s);
    end
    run_sample(-16'sd5, 16'sh1000, 16'sh0000, d, s, lat, br, ro, pa);
    n_vec++;
    if (d !== 16'h7FFB || s !== 1'b0) begin
      n_err++; $display("FAIL neg_small got %h/%b want 7ffb/0", d, s);
    end
  endtask

  task automatic test_integrator();
    logic [15:0] d; logic s, br, ro, pa; int lat;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h800A; exp_d[1] = 16'h8014; exp_d[2] = 16'h801E;
    clear_loop();
    for (int i = 0; i < 3; i++) begin
      run_sample(16'sd10, 16'sh0000, 16'sh1000, d, s, lat, br, ro, pa);
      n_vec++;
      if (d !== exp_d[i] || s !== 1'b0) begin
        n_err++; $display("FAIL integ_step%0d got %h/%b want %h/0", i, d, s, exp_d[i]);
      end
    end
  endtask

  task automatic test_integ_clamp();
    logic [15:0] d; logic s, br, ro, pa; int lat;
    clear_loop();
    // Integrator pins at +32767<<12; output exactly full scale without u clamp.
    run_sample(16'sh7FFF, 16'sh0000, 16'sh7FFF, d, s, lat, br, ro, pa);
    n_vec++;
    if (d !== 16'hFFFF || s !== 1'b0) begin
      n_err++; $display("FAIL iclamp_pos got %h/%b want ffff/0", d, s);
    end
    run_sample(16'sh8000, 16'sh0000, 16'sh7FFF, d, s, lat, br, ro, pa);
    n_vec++;
    if (d !== 16'h0001 || s !== 1'b0) begin
      n_err++; $display("FAIL iclamp_neg got %h/%b want 0001/0", d, s);
    end
  endtask

  task automatic test_disable();
    logic [15:0] d; logic s, br, ro, pa; int lat, seen;
    clear_loop();
    for (int i = 0; i < 3; i++) run_sample(16'sd10, 16'sh0000, 16'sh1000, d, s, lat, br, ro, pa);
    err_in = 16'sd10; kp = 16'sh0000; ki = 16'sh1000; err_valid = 1'b1;
    tick();
    err_valid = 1'b0;
    tick();
    tick();
    enable = 1'b0;
    tick();
    n_vec++;
    if (feedback_data !== 16'h8000 || fb_valid !== 1'b0) begin
      n_err++; $display("FAIL dis_abort got %h/%b want 8000/0", feedback_data, fb_valid);
    end
    n_vec++;
    if (err_ready !== 1'b1 || sat_flag !== 1'b0) begin
      n_err++; $display("FAIL dis_state got r=%b s=%b want r=1 s=0", err_ready, sat_flag);
    end
    err_in = 16'sh7FFF; kp = 16'sh7FFF; err_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (fb_valid) seen++;
    end
    n_vec++;
    if (seen !== 0 || feedback_data !== 16'h8000) begin
      n_err++; $display("FAIL dis_ignore got pulses=%0d data=%h want 0/8000", seen, feedback_data);
    end
    err_valid = 1'b0;
    enable = 1'b1;
    run_sample(16'sd0, 16'sh0000, 16'sh1000, d, s, lat, br, ro, pa);
    n_vec++;
    if (d !== 16'h8000 || lat !== 4) begin
      n_err++; $display("FAIL dis_reenable got %h lat %0d want 8000 lat 4", d, lat);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] d; logic s, br, ro, pa; int lat;
    clear_loop();
    run_sample(16'sh7FFF, 16'sh7FFF, 16'sh1000, d, s, lat, br, ro, pa);
    err_in = 16'sh7FFF; kp = 16'sh7FFF; ki = 16'sh1000; err_valid = 1'b1;
    tick();
    err_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (feedback_data !== 16'h8000 || sat_flag !== 1'b0) begin
      n_err++; $display("FAIL arst_data got %h/%b want 8000/0", feedback_data, sat_flag);
    end
    n_vec++;
    if (fb_valid !== 1'b0 || err_ready !== 1'b1) begin
      n_err++; $display("FAIL arst_ctrl got v=%b r=%b want v=0 r=1", fb_valid, err_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    run_sample(16'sd100, 16'sh1000, 16'sh0000, d, s, lat, br, ro, pa);
    n_vec++;
    if (d !== 16'h8064 || s !== 1'b0 || lat !== 4) begin
      n_err++; $display("FAIL arst_after got %h/%b lat %0d want 8064/0 lat 4", d, s, lat);
    end
  endtask

  task automatic test_back_to_back();
    int first, second, cnt;
    logic [15:0] d1;
    clear_loop();
    first = 0; second = 0; cnt = 0; d1 = '0;
    err_in = -16'sd5; kp = 16'sh1000; ki = 16'sh0000; err_valid = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (fb_valid) begin
        cnt++;
        if (cnt == 1) begin first = i; d1 = feedback_data; end
        if (cnt == 2) second = i;
      end
    end
    err_valid = 1'b0;
    n_vec++;
    if (cnt !== 2 || first !== 5 || second !== 10) begin
      n_err++;
      $display("FAIL b2b_timing got n=%0d at %0d,%0d want n=2 at 5,10", cnt, first, second);
    end
    n_vec++;
    if (d1 !== 16'h7FFB) begin n_err++; $display("FAIL b2b_data got %h want 7ffb", d1); end
  endtask

  task automatic test_slew();
    logic [15:0] d; logic s, br, ro, pa; int lat;
    clear_loop();
`ifdef SLEW_LIMIT_EN
    for (int i = 1; i <= 16; i++) begin
      run_sample(16'sh1000, 16'sh1000, 16'sh0000, d, s, lat, br, ro, pa);
      n_vec++;
      if (d !== 16'(16'h8000 + i * 16'h0100) || s !== (i < 16)) begin
        n_err++;
        $display("FAIL slew_step%0d got %h/%b want %h/%b", i, d, s,
                 16'(16'h8000 + i * 16'h0100), (i < 16));
      end
    end
`else
    run_sample(16'sh1000, 16'sh1000, 16'sh0000, d, s, lat, br, ro, pa);
    n_vec++;
    if (d !== 16'h9000 || s !== 1'b0) begin
      n_err++; $display("FAIL noslew_jump got %h/%b want 9000/0", d, s);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_proportional();
    test_out_clamp();
    test_integrator();
    test_integ_clamp();
    test_disable();
    test_async_reset();
    test_back_to_back();
    test_slew();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
